// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - multi-cycle single-precision float to 32-bit integer converter (FCVT.W.S / FCVT.WU.S)
module float_to_int #(
    parameter int MAX_RSHIFT = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_in,
    input  logic [23:0] man,
    input  logic [7:0]  Exp,
    input  logic        sgn,
    input  logic        zero,
    input  logic        inf,
    input  logic        sNaN,
    input  logic        qNaN,
    input  logic        denormal,
    input  logic [2:0]  rm,
    input  logic        is_unsigned,
    output logic [31:0] int_out,
    output logic        NV,
    output logic        NX,
    output logic        valid_out,
    input  logic        ready_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t      state;
    logic [56:0] w;
    logic        s;
    logic [4:0]  cnt;
    logic        dir_left;
    logic        sgn_r;
    logic        uns_r;
    logic [2:0]  rm_r;

    logic signed [9:0] e_in;
    logic signed [9:0] neg_e;
    logic [4:0]        shift_n;
    logic              direct;
    logic              is_nan;

    logic [31:0] m0;
    logic        g;
    logic        t;
    logic        inexact;
    logic        inc;
    logic [32:0] m;
    logic        nv_c;
    logic [31:0] res;

    // Saturation value; NaN callers pass neg = 0 so NaN saturates like +inf.
    function automatic logic [31:0] saturate(input logic uns, input logic neg);
        if (uns)
            return neg ? 32'h0000_0000 : 32'hFFFF_FFFF;
        return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
    endfunction

    assign ready_in = (state == IDLE);
    assign is_nan   = sNaN | qNaN;
    assign direct   = is_nan | inf | (Exp >= 8'd159);

    always_comb begin
        e_in    = denormal ? -10'sd126 : $signed({2'b00, Exp}) - 10'sd127;
        neg_e   = -e_in;
        shift_n = 5'd0;
        if (e_in > 0)
            shift_n = e_in[4:0];
        else if (e_in < 0)
            shift_n = ($unsigned(neg_e) > 10'(MAX_RSHIFT)) ? 5'(MAX_RSHIFT) : neg_e[4:0];
    end

    always_comb begin
        m0      = w[56:25];
        g       = w[24];
        t       = (|w[23:0]) | s;
        inexact = g | t;
        case (rm_r)
            3'b001:  inc = 1'b0;
            3'b010:  inc = sgn_r & inexact;
            3'b011:  inc = ~sgn_r & inexact;
            3'b100:  inc = g;
            default: inc = g & (t | m0[0]);
        endcase
        m = {1'b0, m0} + {32'd0, inc};
        if (uns_r)
            nv_c = (~sgn_r & m[32]) | (sgn_r & (m != 33'd0));
        else
            nv_c = (~sgn_r & (m > 33'h0_7FFF_FFFF)) | (sgn_r & (m > 33'h0_8000_0000));
        if (nv_c)
            res = saturate(uns_r, sgn_r);
        else if (!uns_r && sgn_r)
            res = 32'd0 - m[31:0];
        else
            res = m[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            int_out   <= 32'd0;
            NV        <= 1'b0;
            NX        <= 1'b0;
            valid_out <= 1'b0;
            w         <= 57'd0;
            s         <= 1'b0;
            cnt       <= 5'd0;
            dir_left  <= 1'b0;
            sgn_r     <= 1'b0;
            uns_r     <= 1'b0;
            rm_r      <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sgn_r    <= sgn;
                        uns_r    <= is_unsigned;
                        rm_r     <= rm;
                        w        <= zero ? 57'd0 : {31'd0, man, 2'b00};
                        s        <= 1'b0;
                        cnt      <= shift_n;
                        dir_left <= (e_in > 0);
                        if (direct) begin
                            int_out   <= saturate(is_unsigned, sgn & ~is_nan);
                            NV        <= 1'b1;
                            NX        <= 1'b0;
                            valid_out <= 1'b1;
                            state     <= DONE;
                        end else if (shift_n == 5'd0) begin
                            state <= ROUND;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (dir_left) begin
                        w <= {w[55:0], 1'b0};
                    end else begin
                        w <= {1'b0, w[56:1]};
                        s <= s | w[0];
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= ROUND;
                end
                ROUND: begin
                    int_out   <= res;
                    NV        <= nv_c;
                    NX        <= inexact & ~nv_c;
                    valid_out <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (ready_out) begin
                        valid_out <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int.sv
// tb/tb_float_to_int.sv - scoreboard bench for float_to_int
module tb_float_to_int;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        valid_in = 1'b0;
    logic        ready_in;
    logic [23:0] man = '0;
    logic [7:0]  Exp = '0;
    logic        sgn = 1'b0;
    logic        zero = 1'b0;
    logic        inf = 1'b0;
    logic        sNaN = 1'b0;
    logic        qNaN = 1'b0;
    logic        denormal = 1'b0;
    logic [2:0]  rm = '0;
    logic        is_unsigned = 1'b0;
    logic [31:0] int_out;
    logic        NV;
    logic        NX;
    logic        valid_out;
    logic        ready_out = 1'b0;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    typedef struct {
        logic [33:0] res;
        int          lat;
    } exp_t;

    typedef struct {
        logic [31:0] f;
        logic [2:0]  r;
        logic        u;
        logic [31:0] v;
        logic        nv;
        logic        nx;
    } case_t;

    exp_t  sb[$];
    case_t cq[$];

    float_to_int dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .man(man), .Exp(Exp), .sgn(sgn), .zero(zero), .inf(inf), .sNaN(sNaN),
        .qNaN(qNaN), .denormal(denormal), .rm(rm), .is_unsigned(is_unsigned),
        .int_out(int_out), .NV(NV), .NX(NX), .valid_out(valid_out), .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [31:0] f);
        int e;
        int n;
        if (f[30:23] == 8'd255 || f[30:23] >= 8'd159)
            return 1;
        e = (f[30:23] == 8'd0) ? -126 : int'(f[30:23]) - 127;
        if (e > 0)       n = e;
        else if (e < 0)  n = (-e > 26) ? 26 : -e;
        else             n = 0;
        return n + 2;
    endfunction

    task automatic add(input logic [31:0] f, input logic [2:0] r, input logic u,
                       input logic [31:0] v, input logic nv, input logic nx);
        case_t c;
        c.f = f; c.r = r; c.u = u; c.v = v; c.nv = nv; c.nx = nx;
        cq.push_back(c);
    endtask

    task automatic push_expected(input case_t c);
        exp_t x;
        x.res = {c.v, c.nv, c.nx};
        x.lat = exp_lat(c.f);
        sb.push_back(x);
    endtask

    task automatic drive_fields(input logic [31:0] f, input logic [2:0] r, input logic u);
        sgn         = f[31];
        Exp         = f[30:23];
        man         = {f[30:23] != 8'd0, f[22:0]};
        zero        = (f[30:23] == 8'd0) && (f[22:0] == 23'd0);
        denormal    = (f[30:23] == 8'd0) && (f[22:0] != 23'd0);
        inf         = (f[30:23] == 8'd255) && (f[22:0] == 23'd0);
        qNaN        = (f[30:23] == 8'd255) && f[22];
        sNaN        = (f[30:23] == 8'd255) && (f[22:0] != 23'd0) && !f[22];
        rm          = r;
        is_unsigned = u;
    endtask

    task automatic run_op(input logic [31:0] f, input logic [2:0] r, input logic u,
                          input bit release_it, output logic [33:0] obs, output int lat);
        int k;
        @(negedge clk);
        k = 0;
        while (!ready_in && k < 200) begin
            @(negedge clk);
            k++;
        end
        drive_fields(f, r, u);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        k = 0;
        while (!valid_out && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        lat = valid_out ? k + 1 : -1;
        obs = {int_out, NV, NX};
        if (release_it) begin
            ready_out = 1'b1;
            @(posedge clk);
            #1 ready_out = 1'b0;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ready_in, valid_out, int_out, NV, NX} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%0b vld=%0b int=%h nv=%0b nx=%0b, want rdy=1 vld=0 int=0 nv=0 nx=0",
                     ready_in, valid_out, int_out, NV, NX);
        end
        reset = 1'b0;
    endtask

    task automatic test_rounding;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        add(32'h4020_0000, RNE, 1'b0, 32'd2, 1'b0, 1'b1);
        add(32'h4020_0000, RMM, 1'b0, 32'd3, 1'b0, 1'b1);
        add(32'h4020_0000, RUP, 1'b0, 32'd3, 1'b0, 1'b1);
        add(32'h4020_0000, RTZ, 1'b0, 32'd2, 1'b0, 1'b1);
        while (cq.size() > 0) begin
            c = cq.pop_front();
            push_expected(c);
            run_op(c.f, c.r, c.u, 1'b1, obs, lat);
            x = sb.pop_front();
            tests++;
            if (obs !== x.res) begin
                fails++;
                $display("FAIL rounding f=%h rm=%0d: got {int,nv,nx}=%h, want %h", c.f, c.r, obs, x.res);
            end
            tests++;
            if (lat !== x.lat) begin
                fails++;
                $display("FAIL rounding_latency f=%h: got %0d, want %0d", c.f, lat, x.lat);
            end
        end
    endtask

    task automatic test_range;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        add(32'hCF00_0000, RTZ, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
        add(32'h4F00_0000, RNE, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        add(32'h4F00_0000, RNE, 1'b1, 32'h8000_0000, 1'b0, 1'b0);
        add(32'h4F80_0000, RNE, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        add(32'hBF33_3333, RNE, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add(32'hBF33_3333, RTZ, 1'b1, 32'h0000_0000, 1'b0, 1'b1);
        while (cq.size() > 0) begin
            c = cq.pop_front();
            push_expected(c);
            run_op(c.f, c.r, c.u, 1'b1, obs, lat);
            x = sb.pop_front();
            tests++;
            if (obs !== x.res) begin
                fails++;
                $display("FAIL range f=%h rm=%0d u=%0b: got {int,nv,nx}=%h, want %h", c.f, c.r, c.u, obs, x.res);
            end
            tests++;
            if (lat !== x.lat) begin
                fails++;
                $display("FAIL range_latency f=%h: got %0d, want %0d", c.f, lat, x.lat);
            end
        end
    endtask

    task automatic test_special;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        add(32'h7FC0_0000, RNE, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0);
        add(32'hFF80_0000, RNE, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
        add(32'h7F80_0001, RTZ, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
        while (cq.size() > 0) begin
            c = cq.pop_front();
            push_expected(c);
            run_op(c.f, c.r, c.u, 1'b1, obs, lat);
            x = sb.pop_front();
            tests++;
            if (obs !== x.res) begin
                fails++;
                $display("FAIL special f=%h u=%0b: got {int,nv,nx}=%h, want %h", c.f, c.u, obs, x.res);
            end
            tests++;
            if (lat !== x.lat) begin
                fails++;
                $display("FAIL special_latency f=%h: got %0d, want %0d", c.f, lat, x.lat);
            end
        end
    endtask

    task automatic test_denormal;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        add(32'h0000_0001, RUP, 1'b0, 32'd1, 1'b0, 1'b1);
        add(32'h0000_0001, RDN, 1'b0, 32'd0, 1'b0, 1'b1);
        add(32'h8000_0001, RDN, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        add(32'h0000_0000, RNE, 1'b0, 32'd0, 1'b0, 1'b0);
        add(32'h8000_0000, RDN, 1'b1, 32'd0, 1'b0, 1'b0);
        while (cq.size() > 0) begin
            c = cq.pop_front();
            push_expected(c);
            run_op(c.f, c.r, c.u, 1'b1, obs, lat);
            x = sb.pop_front();
            tests++;
            if (obs !== x.res) begin
                fails++;
                $display("FAIL denormal f=%h rm=%0d: got {int,nv,nx}=%h, want %h", c.f, c.r, obs, x.res);
            end
            tests++;
            if (lat !== x.lat) begin
                fails++;
                $display("FAIL denormal_latency f=%h: got %0d, want %0d", c.f, lat, x.lat);
            end
        end
    endtask

    task automatic test_backpressure;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        add(32'h4020_0000, RMM, 1'b0, 32'd3, 1'b0, 1'b1);
        c = cq.pop_front();
        push_expected(c);
        run_op(c.f, c.r, c.u, 1'b0, obs, lat);
        x = sb.pop_front();
        tests++;
        if (obs !== x.res || lat !== x.lat) begin
            fails++;
            $display("FAIL backpressure_result: got %h lat %0d, want %h lat %0d", obs, lat, x.res, x.lat);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            tests++;
            if ({int_out, NV, NX, valid_out, ready_in} !== {x.res, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL backpressure_hold cycle %0d: got %h vld=%0b rdy=%0b, want %h vld=1 rdy=0",
                         i, {int_out, NV, NX}, valid_out, ready_in, x.res);
            end
        end
        ready_out = 1'b1;
        @(posedge clk);
        #1 ready_out = 1'b0;
        tests++;
        if ({valid_out, ready_in, int_out, NV, NX} !== {1'b0, 1'b1, x.res}) begin
            fails++;
            $display("FAIL backpressure_release: got vld=%0b rdy=%0b out=%h, want vld=0 rdy=1 out=%h",
                     valid_out, ready_in, {int_out, NV, NX}, x.res);
        end
    endtask

    task automatic test_reset_mid_shift;
        case_t c; exp_t x; logic [33:0] obs; int lat;
        @(negedge clk);
        drive_fields(32'h4F00_0000, RNE, 1'b0);
        valid_in = 1'b1;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        tests++;
        if ({ready_in, valid_out} !== 2'b00) begin
            fails++;
            $display("FAIL busy_in_shift: got rdy=%0b vld=%0b, want rdy=0 vld=0", ready_in, valid_out);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        tests++;
        if ({ready_in, valid_out, int_out, NV, NX} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL reset_mid_shift: got rdy=%0b vld=%0b int=%h nv=%0b nx=%0b, want rdy=1 vld=0 int=0 nv=0 nx=0",
                     ready_in, valid_out, int_out, NV, NX);
        end
        add(32'h42F6_0000, RNE, 1'b0, 32'd123, 1'b0, 1'b0);
        c = cq.pop_front();
        push_expected(c);
        run_op(c.f, c.r, c.u, 1'b1, obs, lat);
        x = sb.pop_front();
        tests++;
        if (obs !== x.res) begin
            fails++;
            $display("FAIL after_reset_result: got %h, want %h", obs, x.res);
        end
        tests++;
        if (lat !== x.lat) begin
            fails++;
            $display("FAIL after_reset_latency: got %0d, want %0d", lat, x.lat);
        end
    endtask

    initial begin
        test_reset;
        test_rounding;
        test_range;
        test_special;
        test_denormal;
        test_backpressure;
        test_reset_mid_shift;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/float_to_int.md
Name: float_to_int

Overview:
- Multi-cycle single-precision float to 32-bit integer converter, implementing RISC-V FCVT.W.S and FCVT.WU.S.
- Sits directly downstream of the FPU operand splitter and consumes its unpacked fields and class flags: mantissa with hidden bit, biased exponent, sign, zero/inf/sNaN/qNaN/denormal.
- Aligns the mantissa with a 1-bit-per-cycle shifter, then rounds, range-checks, and returns the integer and exception flags over a valid/ready handshake.

Parameters:
- MAX_RSHIFT, 26, right-shift cap. Shifts beyond this only feed the sticky bit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  operand valid
- ready_in  out  1  block can accept an operand
- man  in  24  mantissa with hidden bit, from splitter
- Exp  in  8  biased exponent
- sgn  in  1  sign
- zero, inf, sNaN, qNaN, denormal  in  1 each  class flags from splitter
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM, others treated as RNE
- is_unsigned  in  1  1 = FCVT.WU.S, 0 = FCVT.W.S
- int_out  out  32  result
- NV  out  1  invalid-operation flag
- NX  out  1  inexact flag
- valid_out  out  1  result valid
- ready_out  in  1  consumer accepts result

Behaviour:
- Reset: state IDLE; int_out, NV, NX and valid_out all 0; ready_in = 1.
- States: IDLE, SHIFT, ROUND, DONE.
- ready_in = (state == IDLE). Transfer happens when valid_in && ready_in. man, Exp, sgn, flags, rm and is_unsigned are latched on transfer.
- Unbiased exponent e = Exp - 127. A denormal input uses e = -126 with man[23] = 0.
- Working register W, 57 bits:
  - W[56:25] is the integer part, W[24:0] is the fraction.
  - Load W = man << 2, so man[23] sits at W[25].
  - Sticky accumulator S is cleared on load.
- Direct path, taken when sNaN, qNaN, inf or Exp >= 159: IDLE -> DONE. valid_out rises 1 cycle after transfer.
  - Signed: NaN, +inf or positive overflow gives 0x7FFFFFFF; -inf or negative overflow gives 0x80000000.
  - Unsigned: NaN, +inf or positive overflow gives 0xFFFFFFFF; negative gives 0x00000000.
  - NV = 1 and NX = 0 on every direct-path result.
- Normal path:
  - Shift count n = e if e > 0, n = min(-e, MAX_RSHIFT) if e < 0, and n = 0 if e = 0.
  - IDLE -> SHIFT with count n. If n = 0, go straight to ROUND.
  - SHIFT does one bit per cycle: left if e > 0, right if e < 0. On a right shift, S |= W[0]. The counter decrements, and the FSM moves to ROUND when it reaches 1.
- ROUND (1 cycle):
  - Magnitude M0 = W[56:25], guard G = W[24], sticky T = |W[23:0] | S, inexact = G | T.
  - Increment by mode:
    - RNE: G & (T | M0[0])
    - RTZ: 0
    - RDN: sgn & inexact
    - RUP: !sgn & inexact
    - RMM: G
  - M = M0 + inc, computed 33 bits wide.
- Range check, done in ROUND:
  - Signed: NV if (!sgn && M > 2^31 - 1) or (sgn && M > 2^31). A valid result is sgn ? -M : M, truncated to 32 bits.
  - Unsigned: NV if (!sgn && M[32]) or (sgn && M != 0). A valid result is M[31:0].
  - On NV, int_out takes the saturation value of the matching direct-path case.
- Flags: NX = inexact & !NV. -0.0 and +0.0 give 0 with no flags.
- Latency: valid_out asserts n + 2 cycles after transfer on the normal path, and 1 cycle after on the direct path.
- DONE:
  - valid_out = 1; int_out, NV and NX are held stable.
  - On ready_out go to IDLE, with valid_out low in the next cycle.
  - There is no accept in the same cycle as a DONE exit, because ready_in is low in DONE.
  - Outputs keep their value after the exit until the next result is produced.
- Reset asserted in any state, including mid-SHIFT: back to IDLE next cycle, outputs cleared, the in-flight operation is discarded.
- valid_in while busy is ignored; there is no queueing.

Test Plan:
- 0x40200000 (2.5), signed:
  - RNE -> 2, NX = 1.
  - RMM -> 3, NX = 1.
  - RUP -> 3, NX = 1.
  - RTZ -> 2, NX = 1.
- 0xCF000000 (-2^31), signed RTZ -> 0x80000000, no flags, valid_out 33 cycles after transfer.
- 0x4F000000 (2^31):
  - Signed -> 0x7FFFFFFF, NV = 1.
  - Unsigned -> 0x80000000, no flags.
- 0x7FC00000 (qNaN), signed -> 0x7FFFFFFF, NV = 1, valid_out 1 cycle after transfer.
- 0xFF800000 (-inf), unsigned -> 0, NV = 1.
- 0x4F800000 (2^32), unsigned -> 0xFFFFFFFF, NV = 1.
- 0xBF333333 (-0.7), unsigned:
  - RNE -> 0, NV = 1, NX = 0.
  - RTZ -> 0, NX = 1, NV = 0.
- 0x00000001 (smallest denormal), signed:
  - RUP -> 1, NX = 1.
  - RDN -> 0, NX = 1.
  - 0x80000001 with RDN -> 0xFFFFFFFF (-1), NX = 1.
  - 0x00000000 -> 0, no flags.
- Backpressure and reset:
  - Hold ready_out low 5 cycles in DONE -> int_out, NV, NX and valid_out stable, ready_in = 0; release -> IDLE next cycle.
  - Assert reset mid-SHIFT -> state IDLE, valid_out = 0; a following conversion of 0x42F60000 (123.0) -> 123, no flags.
